// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: fetch handshake, then decode/execute/writeback
// for R-type instructions, with a retired-instruction counter.
module multicycle_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [6:0]      opcode,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic            ir_en,
    output logic            pc_en,
    output logic            RegWrite,
    output logic [1:0]      ALUOp,
    output logic            illegal_insn,
    output logic [XLEN-1:0] instret,
    output logic [2:0]      state_dbg
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_NONE  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic [XLEN-1:0] instret_q;
    logic            instret_inc;

    // Where to go once an instruction has finished (retired or skipped).
    function automatic state_t after_insn(input logic run_now);
        return run_now ? S_FETCH : S_IDLE;
    endfunction

    // Counter wraps silently from all-ones to zero.
    function automatic logic [XLEN-1:0] wrap_inc(input logic [XLEN-1:0] v);
        return v + XLEN'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            alu_op_q  <= ALU_NONE;
            instret_q <= '0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            if (instret_inc) begin
                instret_q <= wrap_inc(instret_q);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_op_d     = alu_op_q;
        instret_inc  = 1'b0;
        imem_req     = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        RegWrite     = 1'b0;
        ALUOp        = ALU_NONE;
        illegal_insn = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            // The request stays up until a transfer, regardless of run.
            S_FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_ready;
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    alu_op_d = ALU_RTYPE;
                    state_d  = S_EXECUTE;
                end else begin
                    illegal_insn = 1'b1;
                    pc_en        = 1'b1;
                    state_d      = after_insn(run);
                end
            end

            S_EXECUTE: begin
                ALUOp   = alu_op_q;
                state_d = S_WRITEBACK;
            end

            S_WRITEBACK: begin
                ALUOp       = alu_op_q;
                RegWrite    = 1'b1;
                pc_en       = 1'b1;
                instret_inc = 1'b1;
                state_d     = after_insn(run);
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: reset table, directed corner sequences and random
// stimulus, all checked against a cycle-offset reference model of the sequencing rules.
module tb_multicycle_ctrl;

    localparam int XLEN = 64;
    localparam logic [6:0] OP_R = 7'b0110011;

    logic            clk;
    logic            rst_n;
    logic            run;
    logic [6:0]      opcode;
    logic            imem_ready;
    logic            imem_req;
    logic            ir_en;
    logic            pc_en;
    logic            RegWrite;
    logic [1:0]      ALUOp;
    logic            illegal_insn;
    logic [XLEN-1:0] instret;
    logic [2:0]      state_dbg;

    int vectors;
    int miscompares;

    multicycle_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .imem_ready(imem_ready), .imem_req(imem_req), .ir_en(ir_en),
        .pc_en(pc_en), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .illegal_insn(illegal_insn), .instret(instret), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within an instruction is counted in cycles since
    // the fetch transfer; the state code equals that offset plus one.
    typedef enum {PH_IDLE, PH_FETCH, PH_BUSY} phase_t;
    phase_t          m_phase;
    int              m_k;
    logic [XLEN-1:0] m_instret;

    typedef struct {
        logic            r;
        logic            rdy;
        logic [6:0]      op;
        logic [9:0]      ctl;
        logic [XLEN-1:0] ins;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [9:0] dut_ctl();
        return {imem_req, ir_en, pc_en, RegWrite, ALUOp, illegal_insn, state_dbg};
    endfunction

    task automatic check(input string name, input logic [9:0] exp_c, input logic [XLEN-1:0] exp_i);
        logic [9:0] act_c;
        act_c = dut_ctl();
        vectors++;
        if (act_c !== exp_c || instret !== exp_i) begin
            miscompares++;
            $display("FAIL %s: got ctl=%b instret=%0d, expected ctl=%b instret=%0d",
                     name, act_c, instret, exp_c, exp_i);
        end
    endtask

    task automatic check_val(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_k       = 0;
        m_instret = '0;
    endtask

    // Apply one cycle of inputs, check outputs against the model, advance past the edge.
    task automatic step(input logic r, input logic rdy, input logic [6:0] op);
        logic e_req, e_ir, e_pc, e_rw, e_ill;
        logic [1:0] e_alu;
        logic [2:0] e_st;
        phase_t n_phase;
        int n_k;
        logic [XLEN-1:0] n_ins;
        run = r; imem_ready = rdy; opcode = op;
        #1;
        e_req = 0; e_ir = 0; e_pc = 0; e_rw = 0; e_ill = 0; e_alu = 2'b00; e_st = 3'd0;
        n_phase = m_phase; n_k = m_k; n_ins = m_instret;
        case (m_phase)
            PH_IDLE: if (r) n_phase = PH_FETCH;
            PH_FETCH: begin
                e_st = 3'd1; e_req = 1; e_ir = rdy;
                if (rdy) begin n_phase = PH_BUSY; n_k = 1; end
            end
            default: begin
                e_st = 3'(m_k + 1);
                if (m_k == 1) begin
                    if (op == OP_R) n_k = 2;
                    else begin
                        e_ill = 1; e_pc = 1;
                        n_phase = r ? PH_FETCH : PH_IDLE;
                    end
                end else if (m_k == 2) begin
                    e_alu = 2'b10; n_k = 3;
                end else begin
                    e_alu = 2'b10; e_rw = 1; e_pc = 1;
                    n_ins = m_instret + 1;
                    n_phase = r ? PH_FETCH : PH_IDLE;
                end
            end
        endcase
        check("model", {e_req, e_ir, e_pc, e_rw, e_alu, e_ill, e_st}, m_instret);
        m_phase = n_phase; m_k = n_k; m_instret = n_ins;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] pat[4];
        int cnt;
        vectors = 0;
        miscompares = 0;

        // Three back-to-back R-type instructions with zero-wait memory.
        pat[0] = 10'b11_0_0_00_0_001;
        pat[1] = 10'b00_0_0_00_0_010;
        pat[2] = 10'b00_0_0_10_0_011;
        pat[3] = 10'b00_1_1_10_0_100;
        tbl[0] = '{r: 1'b1, rdy: 1'b1, op: OP_R, ctl: 10'b0, ins: '0};
        for (int i = 1; i < 13; i++) begin
            tbl[i] = '{r: 1'b1, rdy: 1'b1, op: OP_R, ctl: pat[(i - 1) % 4], ins: XLEN'((i - 1) / 4)};
        end

        rst_n = 0; run = 1; imem_ready = 1; opcode = OP_R;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 10'b0, '0);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].rdy, tbl[i].op);
            #1;
            // step left us just after the edge; compare the row against the previous cycle
        end
        // The table rows are re-applied with explicit expectations on a fresh reset.
        rst_n = 0;
        #1;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 13; i++) begin
            run = tbl[i].r; imem_ready = tbl[i].rdy; opcode = tbl[i].op;
            #1;
            check($sformatf("table%0d", i), tbl[i].ctl, tbl[i].ins);
            step(tbl[i].r, tbl[i].rdy, tbl[i].op);
        end
        check_val("instret_after3", instret, 3);

        // Fetch with 5 wait cycles: the whole instruction takes 9 cycles.
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run = 1; imem_ready = 0; opcode = OP_R;
            #1;
            check_val("wait_req", {63'b0, imem_req}, 1);
            check_val("wait_ir_en", {63'b0, ir_en}, 0);
            step(1, 0, OP_R);
            cnt++;
        end
        step(1, 1, OP_R);
        cnt++;
        check_val("decode_after_ready", {61'b0, state_dbg}, 2);
        for (int i = 0; i < 10 && RegWrite !== 1'b1; i++) begin
            step(1, 1, OP_R);
            cnt++;
            run = 1; imem_ready = 1; opcode = OP_R;
            #1;
        end
        cnt++;
        check_val("wait_insn_len", XLEN'(cnt), 9);
        step(1, 1, OP_R);

        // Illegal opcode: one-cycle illegal/pc_en pulse in DECODE, then FETCH.
        step(1, 1, OP_R);
        run = 1; imem_ready = 0; opcode = 7'b0000011;
        #1;
        check("illegal_decode", 10'b00_1_0_00_1_010, 4);
        step(1, 0, 7'b0000011);
        check_val("illegal_next_fetch", {61'b0, state_dbg}, 1);
        check_val("illegal_instret", instret, 4);

        // run dropped during EXECUTE: writeback still retires, then park in IDLE.
        step(1, 1, OP_R);
        step(1, 1, OP_R);
        step(0, 1, OP_R);
        run = 0;
        #1;
        check_val("rundrop_regwrite", {63'b0, RegWrite}, 1);
        step(0, 1, OP_R);
        for (int i = 0; i < 3; i++) begin
            run = 0; imem_ready = 1;
            #1;
            check_val("rundrop_no_req", {63'b0, imem_req}, 0);
            step(0, 1, OP_R);
        end
        check_val("rundrop_instret", instret, 5);

        // Async reset during EXECUTE aborts the instruction.
        step(1, 1, OP_R);
        step(1, 1, OP_R);
        step(1, 1, OP_R);
        run = 1; imem_ready = 1; opcode = OP_R;
        #1;
        check_val("pre_reset_exec", {61'b0, state_dbg}, 3);
        rst_n = 0;
        #1;
        check("async_reset", 10'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 6; i++) step(1, 1, OP_R);

        // Counter wrap from all-ones.
        while (state_dbg !== 3'd0 && cnt < 200) begin
            step(0, 1, OP_R);
            cnt++;
        end
        force dut.instret_q = '1;
        m_instret = '1;
        step(0, 0, OP_R);
        release dut.instret_q;
        step(0, 0, OP_R);
        check_val("preload_ones", instret, '1);
        for (int i = 0; i < 5; i++) step(1, 1, OP_R);
        check_val("wrap_zero", instret, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 1) == 1) ? OP_R : 7'($urandom);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, op);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
